// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes shared with decode, FSM state encoding and shift-op helper.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_barrel_shift.sv
// alu_barrel_shift: single-cycle SLL/SRL/SRA by shamt; only built with ALU_BARREL_SHIFT_EN.
`ifdef ALU_BARREL_SHIFT_EN
module alu_barrel_shift
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [3:0]         op,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  y
);
    assign y = op == ALU_SLL ? a << shamt :
               op == ALU_SRA ? DATA_W'($signed(a) >>> shamt) :
                               a >> shamt;
endmodule
`endif

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational one-bit shift (SLL/SRL/SRA) of a DATA_W word.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y
);
    assign y = op == ALU_SLL ? {a[DATA_W-2:0], 1'b0} :
               op == ALU_SRA ? {a[DATA_W-1], a[DATA_W-1:1]} :
                               {1'b0, a[DATA_W-1:1]};
endmodule

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: EX-stage ALU with valid/ready on both sides; shifts iterate one bit per cycle
// unless ALU_BARREL_SHIFT_EN selects the single-cycle barrel shifter.
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_ALUControlLines,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_illegal,
    output logic              o_valid,
    input  logic              i_ready
);
    logic [1:0]         state;
    logic [3:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  sh_out;
    logic [DATA_W-1:0]  alu_out;
    logic               lt_s;
    logic               lt_u;
    logic               illegal_op;

    assign op         = i_ALUControlLines;
    assign shamt      = i_B[SHAMT_W-1:0];
    assign lt_s       = $signed(i_A) < $signed(i_B);
    assign lt_u       = i_A < i_B;
    assign illegal_op = op > ALU_AND;

`ifdef ALU_BARREL_SHIFT_EN
    alu_barrel_shift #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shift (
        .op(op), .a(i_A), .shamt(shamt), .y(sh_out)
    );
`else
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  step;
    logic [SHAMT_W-1:0] cnt;
    logic [3:0]         op_q;
    // A zero-amount shift in IDLE simply passes A through.
    assign sh_out = i_A;
    alu_shift_step #(.DATA_W(DATA_W)) u_shift (.op(op_q), .a(work), .y(step));
`endif

    always_comb
        alu_out = op == ALU_ADD  ? i_A + i_B :
                  op == ALU_SUB  ? i_A - i_B :
                  op == ALU_SLT  ? {{(DATA_W-1){1'b0}}, lt_s} :
                  op == ALU_SLTU ? {{(DATA_W-1){1'b0}}, lt_u} :
                  op == ALU_XOR  ? i_A ^ i_B :
                  op == ALU_OR   ? i_A | i_B :
                  op == ALU_AND  ? i_A & i_B :
                  is_shift(op)   ? sh_out : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_result  <= '0;
            o_zero    <= 1'b0;
            o_illegal <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            work      <= '0;
            cnt       <= '0;
            op_q      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (i_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift(op) && shamt != '0) begin
                        state <= ST_SHIFT;
                        work  <= i_A;
                        cnt   <= shamt;
                        op_q  <= op;
                    end else
`endif
                    begin
                        state     <= ST_DONE;
                        o_result  <= alu_out;
                        o_zero    <= alu_out == '0;
                        o_illegal <= illegal_op;
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    work <= step;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= ST_DONE;
                        o_result  <= step;
                        o_zero    <= step == '0;
                        o_illegal <= 1'b0;
                    end
                end
`endif
                ST_DONE: if (i_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = state == ST_IDLE;
    assign o_valid = state == ST_DONE;
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: directed vectors; a driver queues expected results, a monitor checks them.
module tb_alu_iter_exec;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  ctl = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        valid = 0;
    logic        ready = 1;
    logic        o_ready, o_zero, o_illegal, o_valid;
    logic [31:0] o_result;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          vcyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    bit   seen = 0;

    alu_iter_exec dut (
        .i_clk(clk), .i_rst(rst), .i_ALUControlLines(ctl), .i_A(a), .i_B(b),
        .i_valid(valid), .o_ready(o_ready), .o_result(o_result), .o_zero(o_zero),
        .o_illegal(o_illegal), .o_valid(o_valid), .i_ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int shift_lat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return n == 0 ? 1 : 1 + n;
`endif
    endfunction

    // Monitor: pops one expectation per result presented.
    always @(negedge clk) begin
        if (rst || !o_valid) seen = 0;
        else if (!seen) begin
            seen = 1;
            if (q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("result", o_result, e.res);
                check("zero", {31'd0, o_zero}, {31'd0, e.zero});
                check("illegal", {31'd0, o_illegal}, {31'd0, e.ill});
                check("latency", cyc, e.vcyc);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] r, input logic z, input logic il, input int lat);
        int t = 0;
        while (!o_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!o_ready) check("ready_timeout", 32'd0, 32'd1);
        ctl = op; a = av; b = bv; valid = 1;
        q.push_back('{r, z, il, cyc + lat});
        @(negedge clk);
        valid = 0;
        a = $urandom;
        b = $urandom;
        ctl = 4'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || !o_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [31:0] held;
        int t;
        @(negedge clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        issue(4'b0000, 32'd5, 32'd7, 32'd12, 0, 0, 1);
        issue(4'b0001, 32'h1234, 32'h1234, 32'd0, 1, 0, 1);
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1);
        issue(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1);
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1);
        issue(4'b0101, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 0, 0, 1);
        issue(4'b1000, 32'hA000_0005, 32'h0500_0030, 32'hA500_0035, 0, 0, 1);
        issue(4'b1001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 0, 0, 1);
        issue(4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, shift_lat(4));
        issue(4'b0110, 32'h8000_0000, 32'd4, 32'h0800_0000, 0, 0, shift_lat(4));
        issue(4'b0010, 32'd1, 32'd31, 32'h8000_0000, 0, 0, shift_lat(31));
        issue(4'b0010, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 0, 0, 1);
        issue(4'b1100, 32'd5, 32'd9, 32'd0, 1, 1, 1);
        issue(4'b1010, 32'd5, 32'd9, 32'd0, 1, 1, 1);
        issue(4'b0000, 32'd1, 32'd2, 32'd3, 0, 0, 1);
        drain();

        // Backpressure: result and handshake must hold while the consumer stalls.
        ready = 0;
        issue(4'b0001, 32'd10, 32'd3, 32'd7, 0, 0, 1);
        t = 0;
        while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        held = o_result;
        check("bp_held_value", held, 32'd7);
        repeat (6) begin
            @(negedge clk);
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_result", o_result, 32'd7);
        end
        ready = 1;
        @(negedge clk);
        check("bp_valid_drop", {31'd0, o_valid}, 32'd0);
        check("bp_ready_rise", {31'd0, o_ready}, 32'd1);

        // Reset in the middle of a 10-bit shift discards it.
        issue(4'b0110, 32'hFFFF_0000, 32'd10, 32'h003F_FFC0, 0, 0, shift_lat(10));
        @(negedge clk);
        @(negedge clk);
        void'(q.pop_back());
        rst = 1;
        #1;
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_result", o_result, 32'd0);
        check("mid_rst_zero", {31'd0, o_zero}, 32'd0);
        check("mid_rst_illegal", {31'd0, o_illegal}, 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);

        issue(4'b1100, 32'h1234, 32'h5678, 32'd0, 1, 1, 1);
        issue(4'b0111, 32'h4000_0001, 32'd3, 32'h0800_0000, 0, 0, shift_lat(3));
        drain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
- Execution end of the ALU control interface: consumes the 4-bit ALU control code produced by the decode stage plus two operands, and produces the result.
- Add, sub, logic and compare ops finish in one cycle. Shifts iterate one bit per cycle (area-lean core option).
- Sits in EX between operand muxes and the EX/MEM register; valid/ready handshake on both sides so the pipeline can stall on it.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ALUControlLines  in  4  operation code.
- i_A  in  DATA_W  operand A (shift source).
- i_B  in  DATA_W  operand B (shift amount = i_B[SHAMT_W-1:0]).
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- o_result  out  DATA_W  result, valid while o_valid.
- o_zero  out  1  o_result == 0 (branch compare).
- o_illegal  out  1  unsupported op code was issued.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts result.

Behaviour:
- Reset is asynchronous: state=IDLE, o_result=0, o_zero=0, o_illegal=0, o_valid=0, shift counter=0. Any in-flight op is discarded, including mid-shift.
- o_ready = (state==IDLE). A request is accepted on the rising edge where i_valid && o_ready. Operands and op code are captured; inputs are don't-care afterwards.
- Op codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001. Codes 1010-1111 are illegal.
- ADD/SUB wrap modulo 2^DATA_W with no overflow flag.
- SLT is a signed compare and SLTU an unsigned compare; both produce 1 or 0, zero-extended.
- States:
  - IDLE: on accept of a non-shift op, an illegal op, or a shift with shamt==0 -> DONE, with the result registered the same edge. On accept of a shift with shamt!=0 -> SHIFT, with the working register loaded with i_A and the counter with shamt.
  - SHIFT: each cycle the working register shifts by 1 (SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates the MSB) and the counter decrements. On the edge where counter==1, the shifted value goes to o_result -> DONE.
  - DONE: o_valid=1 and o_result, o_zero, o_illegal are held stable until i_ready=1. On that edge -> IDLE and o_valid drops.
- Latency, with the accept at edge k:
  - non-shift ops and shamt==0: o_valid high after edge k+1.
  - shift by n: o_valid high after edge k+1+n; maximum n=31 gives 32 cycles.
- Because o_ready is low in DONE, a new accept cannot coincide with result retirement. Steady-state throughput is one op per 2 cycles minimum.
- Illegal code: o_result=0, o_zero=1, o_illegal=1 for that result only, latency 1.
- o_zero is registered together with o_result and is never computed combinationally from o_result.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined: all shifts complete via a single-cycle barrel shifter with the same latency as ADD. The SHIFT state and counter are not instantiated, and the handshake is unchanged.
- Undefined: iterative shift as described above.

Decomposition:
- Package alu_pkg holds:
  - the ten ALU op code constants (shared with the decode stage);
  - the state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - a function that flags shift op codes.
- One sub-module: alu_shift_step. It is combinational, one-bit shift of a DATA_W word by op (SLL/SRL/SRA). Under ALU_BARREL_SHIFT_EN it is replaced by an alu_barrel_shift variant with the same interface plus a shamt input.

Test Plan:
- ADD A=5, B=7, i_ready=1 -> o_valid one cycle after accept, o_result=12, o_zero=0. Repeat with SUB A=B=0x1234 -> o_result=0, o_zero=1.
- SLT A=0xFFFFFFFF, B=1 -> o_result=1; SLTU with the same operands -> 0.
- SRA A=0x80000000, B=4 -> o_ready low for 4 cycles, o_valid after edge k+5, o_result=0xF8000000. SRL with the same operands -> 0x08000000. SLL A=1, B=31 -> 0x80000000 at k+32.
- SLL with B=0x20 (shamt 0) -> o_result=A after 1 cycle, no SHIFT state entered.
- Backpressure: hold i_ready=0 for 6 cycles after o_valid -> o_result/o_valid stable and o_ready=0 throughout; i_ready=1 -> o_valid drops next edge and o_ready rises.
- Assert i_rst mid-shift (cycle 3 of a 10-bit SRL) -> all outputs 0 immediately, o_ready=1 after release. Op code 1100 -> o_illegal=1, o_result=0.
